// File: rtl/serial_arith_pkg.sv
// Shared FSM encoding and default operand width for the serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: LSB-first, one bit per clock, with
// valid/ready handshakes on the operand and result sides.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             bor;
    logic [CW-1:0]    cnt;
    logic             bit_d;
    logic             bit_bout;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bor),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_valid) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    if (done_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign start_ready = (state == IDLE);
    assign done_valid  = (state == DONE);

    // Operands shift out at bit 0; each difference bit enters at the MSB so
    // that after WIDTH shifts the result sits in natural bit order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            bor  <= 1'b0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sr <= A;
                        b_sr <= B;
                        bor  <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    d_sr <= {bit_d, d_sr[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    bor  <= bit_bout;
                    cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign D    = d_sr;
    assign BOUT = bor;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random stimulus for serial_subtractor (WIDTH=8) with a result queue.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] D;
    logic         BOUT;
    logic         done_valid;
    logic         done_ready;

    typedef struct packed {
        logic         b;
        logic [W-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   fails;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .A           (A),
        .B           (B),
        .D           (D),
        .BOUT        (BOUT),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge following the acceptance edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int   n;
        exp_t e;
        n = 0;
        A = a;
        B = b;
        start_valid = 1'b1;
        while (!start_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(start_ready), 32'd1);
        e.d = a - b;
        e.b = (a < b);
        exp_q.push_back(e);
        @(negedge clk);
        if (hold) begin
            A = 8'hFF;
            B = 8'h00;
        end else begin
            start_valid = 1'b0;
            A = 8'($urandom);
            B = 8'($urandom);
        end
    endtask

    task automatic wait_done(input int delay, input bit pre);
        int   c;
        exp_t e;
        c = 0;
        if (pre) done_ready = 1'b1;
        while (!done_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("latency", 32'(c), 32'(W));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("D", 32'(D), 32'(e.d));
        check("BOUT", 32'(BOUT), 32'(e.b));
        if (!pre) begin
            for (int i = 0; i < delay; i++) begin
                check("bp_done_valid", 32'(done_valid), 32'd1);
                check("bp_start_ready", 32'(start_ready), 32'd0);
                check("bp_D", 32'(D), 32'(e.d));
                check("bp_BOUT", 32'(BOUT), 32'(e.b));
                @(negedge clk);
            end
            done_ready = 1'b1;
        end
        @(negedge clk);
        done_ready = 1'b0;
        check("idle_start_ready", 32'(start_ready), 32'd1);
        check("idle_done_valid", 32'(done_valid), 32'd0);
        check("hold_D", 32'(D), 32'(e.d));
        check("hold_BOUT", 32'(BOUT), 32'(e.b));
    endtask

    initial begin
        int seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        checks = 0;
        fails = 0;
        rst = 1'b1;
        start_valid = 1'b0;
        done_ready = 1'b0;
        A = '0;
        B = '0;

        #3;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_D", 32'(D), 32'd0);
        check("rst_BOUT", 32'(BOUT), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        start_op(8'h05, 8'h03, 1'b0);
        wait_done(0, 1'b0);
        start_op(8'h03, 8'h05, 1'b0);
        wait_done(0, 1'b1);
        start_op(8'h00, 8'hFF, 1'b0);
        wait_done(1, 1'b0);
        start_op(8'hA5, 8'hA5, 1'b0);
        wait_done(0, 1'b0);

        // Result held under five cycles of backpressure
        start_op(8'h3C, 8'hC3, 1'b0);
        wait_done(5, 1'b0);

        // start_valid held through RUN/DONE; second op only after IDLE
        start_op(8'h05, 8'h03, 1'b1);
        wait_done(2, 1'b0);
        start_op(8'hFF, 8'h00, 1'b0);
        wait_done(0, 1'b0);

        // Reset in the middle of RUN
        start_op(8'h80, 8'h01, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_start_ready", 32'(start_ready), 32'd1);
        check("arst_done_valid", 32'(done_valid), 32'd0);
        check("arst_D", 32'(D), 32'd0);
        check("arst_BOUT", 32'(BOUT), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_valid) seen++;
        end
        check("no_partial_done", 32'(seen), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_op(8'h10, 8'h01, 1'b0);
        wait_done(0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            start_op(ra, rb, 1'b0);
            wait_done(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
